// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

   // Controller states; 2-bit encoding is visible on the debug state port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_e;

   localparam int WIDTH_DEF = 8;

   // Bit-position counter width; it only has to reach WIDTH-1.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Operation bus between a controller (master) and the serial subtractor (slave).
//
// Handshake: the master raises start together with stable a/b/bin; the request
// is taken on the first rising edge where start=1 and busy=0 (IDLE or DONE cycle).
// Operands are sampled only on that edge. While busy=1, start is ignored.
// done is a one-cycle pulse marking the cycle in which diff/bout/ovf first
// show the new result; those outputs then hold until the next done.
interface serial_subtractor_8bit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor_8bit_cell.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor_1bit (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor_8bit
   import sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_subtractor_8bit_if.slave bus,
   output sub_state_e              state_o
);
   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sub_state_e       state_q, state_d;
   logic             accept;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d, ovf_q, ovf_d;
   logic             cell_d, cell_bo;

   full_subtractor_1bit u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // Next-state logic; a request is taken whenever the block is not running.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      brw_d  = brw_q;
      diff_d = diff_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      if (accept) begin
         a_d   = bus.a;
         b_d   = bus.b;
         brw_d = bus.bin;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         a_d   = {1'b0, a_q[WIDTH-1:1]};
         b_d   = {1'b0, b_q[WIDTH-1:1]};
         res_d = {cell_d, res_q[WIDTH-1:1]};
         brw_d = cell_bo;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            // On the last bit a_q[0]/b_q[0] are the operand sign bits.
            diff_d = {cell_d, res_q[WIDTH-1:1]};
            bout_d = cell_bo;
            ovf_d  = (a_q[0] ^ b_q[0]) & (cell_d ^ a_q[0]);
         end
      end
   end

   // State and datapath registers; async reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for the bit-serial subtractor: directed cases, handshake/reset cases,
// and a random sweep against an arithmetic reference model.
module tb_serial_subtractor_8bit;
   import sub_pkg::*;

   localparam int W = 8;

   // Clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_subtractor_8bit_if #(.WIDTH(W)) bus ();
   sub_state_e dut_state;

   serial_subtractor_8bit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (dut_state)
   );

   int n_checks = 0;
   int n_err    = 0;
   int pending  = 0;

   // Expected {ovf, bout, diff} per accepted operation, in order.
   logic [W+1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic bin);
      int ua, ub, u, sa, sb, s;
      logic ov, bo;
      logic [W-1:0] d;
      ua = int'(a);
      ub = int'(b);
      u  = ua - ub - int'(bin);
      bo = (u < 0);
      d  = W'(u);
      sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
      sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
      s  = sa - sb - int'(bin);
      ov = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
      return {ov, bo, d};
   endfunction

   // Driver: present a request for one edge; caller ensures busy=0 at that edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      bus.start = 1'b1;
      exp_q.push_back(ref_model(a, b, bin));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait (bounded) for done, check latency from the accept edge and the result.
   task automatic wait_check(input string tag, input int exp_lat);
      int lat;
      logic [W+1:0] e;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_diff"}, bus.diff, e[W-1:0]);
         chk({tag, "_bout"}, bus.bout, e[W]);
         chk({tag, "_ovf"},  bus.ovf,  e[W+1]);
      end
   endtask

   // done must always be preceded by an accepted request.
   always @(negedge rst_n) pending = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done === 1'b1) begin
            chk("spurious_done", (pending > 0), 1);
            if (pending > 0) pending--;
         end
         if (bus.start === 1'b1 && bus.busy === 1'b0) pending++;
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", dut_state, IDLE);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_diff",  bus.diff, 0);
      chk("rst_bout",  bus.bout, 0);
      chk("rst_ovf",   bus.ovf,  0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic subtraction, latency and pulse width
      start_op(8'h3C, 8'h15, 1'b0);
      chk("t1_busy", bus.busy, 1);
      wait_check("t1", 8);
      chk("t1_diff_const", bus.diff, 32'h27);
      @(posedge clk);
      #1;
      chk("t1_done_width", bus.done, 0);
      chk("t1_hold_diff",  bus.diff, 32'h27);

      start_op(8'h00, 8'h01, 1'b0);
      wait_check("t2", 8);
      chk("t2_diff_const", bus.diff, 32'hFF);

      start_op(8'h7F, 8'hFF, 1'b0);
      wait_check("t3a", 8);
      chk("t3a_ovf_const", bus.ovf, 1);
      start_op(8'h80, 8'h01, 1'b0);
      wait_check("t3b", 8);
      chk("t3b_diff_const", bus.diff, 32'h7F);

      start_op(8'h05, 8'h05, 1'b1);
      wait_check("t4a", 8);
      chk("t4a_bout_const", bus.bout, 1);
      start_op(8'h05, 8'h05, 1'b0);
      wait_check("t4b", 8);
      chk("t4b_diff_const", bus.diff, 0);

      // Handshake: start while busy is ignored; start in DONE is back-to-back
      start_op(8'hA5, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      bus.a     = 8'h11;
      bus.b     = 8'h99;
      bus.bin   = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("t5_busy_ignore", bus.busy, 1);
      wait_check("t5a", 4);
      chk("t5a_diff_const", bus.diff, 32'h69);
      start_op(8'h20, 8'h30, 1'b1);
      chk("t5_b2b_done_low", bus.done, 0);
      chk("t5_b2b_busy",     bus.busy, 1);
      wait_check("t5b", 8);

      // Reset mid-run: outputs clear at once, no done for the aborted op
      start_op(8'h7F, 8'hFF, 1'b0);
      wait_check("t6pre", 8);
      start_op(8'h44, 8'h22, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_busy",  bus.busy, 0);
      chk("t6_done",  bus.done, 0);
      chk("t6_diff",  bus.diff, 0);
      chk("t6_bout",  bus.bout, 0);
      chk("t6_ovf",   bus.ovf,  0);
      chk("t6_state", dut_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_op(8'h10, 8'h01, 1'b0);
      wait_check("t6post", 8);
      chk("t6post_diff_const", bus.diff, 32'h0F);

      // Random sweep with a mix of back-to-back and idle gaps
      for (int i = 0; i < 1000; i++) begin
         start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
         wait_check("rand", 8);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
